sync_fifo_fwft: RTL and testbench
=================================

SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 Parameter WIDTH, default 48: data word width in bits, >=1.
REQ-002 Parameter DEPTH, default 5: total capacity in words, >=2, any integer (power of two not required).
REQ-003 Parameter AFULL_TH, default DEPTH-1: almost_full asserts when count >= AFULL_TH, range 1..DEPTH.
REQ-004 Parameter RD_EDGE, default 0: 0 = level read (one pop per cycle); 1 = rising-edge read (one pop per rd_en rising edge, legacy mode).
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 wr_en  input  1  push request.
REQ-008 wr_data  input  WIDTH  push data.
REQ-009 rd_en  input  1  pop request.
REQ-010 clr_err  input  1  clears sticky ovf/udf.
REQ-011 rd_data  output  WIDTH  head word, first-word-fall-through.
REQ-012 rd_valid  output  1  rd_data holds a valid head word.
REQ-013 full, empty, almost_full  output  1 each  occupancy flags, registered.
REQ-014 count  output  CNT_W=$clog2(DEPTH+1)  words held, 0..DEPTH.
REQ-015 ovf, udf  output  1 each  sticky overflow / underflow error flags.

Function
REQ-016 pop SHALL be rd_en & rd_valid (RD_EDGE=0), or rd_en & ~rd_en_q & rd_valid (RD_EDGE=1, rd_en_q = rd_en registered one cycle).
REQ-017 push SHALL be wr_en & (~full | pop); a write while full is accepted only with a simultaneous pop.
REQ-018 Storage: DEPTH-1-entry array plus one output register; count covers both; capacity exactly DEPTH.
REQ-019 Write into empty FIFO SHALL give rd_valid=1 and rd_data=that word one cycle after the write edge.
REQ-020 On pop, next word SHALL appear on rd_data in the following cycle; rd_valid stays high if count after pop >= 1.
REQ-021 rd_data SHALL hold its value while rd_valid=1 and no pop; it is don't-care while rd_valid=0.
REQ-022 Read/write pointers SHALL wrap from DEPTH-2 to 0 (array index), independent of power-of-two.
REQ-023 count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-024 full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_TH), all reflecting post-edge count.
REQ-025 Order SHALL be strict FIFO; no word lost or duplicated, including simultaneous push/pop at empty, at full, and at pointer wrap.
REQ-026 ovf SHALL set on wr_en & full & ~pop (word dropped, state unchanged otherwise).
REQ-027 udf SHALL set on rd_en & ~rd_valid (RD_EDGE=0) or rd_en rising edge & ~rd_valid (RD_EDGE=1); no state change.
REQ-028 clr_err clears ovf/udf next edge; a same-cycle error event SHALL win over clr_err.

Reset
REQ-029 rst=0 at a clock edge SHALL set count=0, empty=1, full=0, almost_full=0, rd_valid=0, ovf=0, udf=0, pointers=0, rd_en_q=0.
REQ-030 Reset mid-operation SHALL discard all contents; array contents need not be cleared; rd_data undefined until first valid word.
REQ-031 Reset SHALL dominate wr_en, rd_en and clr_err in the same cycle.

Structure
REQ-032 Package fifo_pkg SHALL hold the RD_EDGE mode constants (RD_LEVEL=0, RD_RISE=1) and a count-width function.
REQ-033 Storage array SHALL be a separate sub-module fifo_ram (1 write port, 1 async read port, WIDTH x DEPTH-1) for tool-specific RAM mapping.
REQ-034 Control, flags and output register SHALL reside in sync_fifo_fwft.

Verification
REQ-035 DEPTH=5: push 0xA1..0xA5 back-to-back -> full=1, count=5, almost_full from count 4; 6th push 0xA6 -> ovf=1, count=5, reads return A1..A5 exactly.
REQ-036 Empty FIFO: push 0x11 at edge N -> rd_valid=1, rd_data=0x11 at N+1; pop at N+1 -> empty=1, rd_valid=0 at N+2.
REQ-037 Full FIFO, simultaneous push 0xB0 and pop -> count stays 5, ovf=0, 0xB0 emerges fifth.
REQ-038 Continuous push/pop 20 words 0..19 at DEPTH=5 (pointer wraps several times) -> output 0..19 in order, count constant.
REQ-039 RD_EDGE=1, 3 words stored, rd_en held high 4 cycles -> exactly one pop, count=2; rd_en on empty -> udf=1, clr_err -> udf=0.
REQ-040 Reset asserted with count=3 -> next cycle count=0, empty=1, rd_valid=0, ovf=udf=0; new push then read returns new word only.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the first-word-fall-through FIFO.
//   RD_LEVEL / RD_RISE : read-mode selectors for sync_fifo_fwft.RD_EDGE
//   cnt_width()        : width of a counter spanning 0..depth
//   ptr_width()        : width of an index into a words-deep array (min 1)
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int RD_LEVEL = 0;  // one pop per cycle while rd_en is high
  localparam int RD_RISE  = 1;  // one pop per rd_en rising edge

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// Simple storage array: one synchronous write port, one asynchronous read
// port. Kept in its own module so it can be swapped for a vendor RAM.
// Contents are not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write word
//   i_raddr : read index
//   o_rdata : word at i_raddr (combinational)
// ---------------------------------------------------------------------------
module fifo_ram #(
  parameter int WIDTH = 48,
  parameter int WORDS = 4,
  parameter int AW    = 2
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Synchronous first-word-fall-through FIFO. Capacity DEPTH words held as a
// (DEPTH-1)-entry array plus one output register that presents the head
// word directly on rd_data.
//
// Handshake: rd_valid means rd_data is the current head word. A pop happens
// when a read request (rd_en level, or rd_en rising edge when RD_EDGE=1)
// meets rd_valid=1; the next word is shown the following cycle. A push
// happens when wr_en is high and the FIFO is not full, or is full but pops
// in the same cycle. Requests that cannot be honoured set sticky ovf/udf.
//
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   wr_en, wr_data     : push request and word
//   rd_en              : pop request
//   clr_err            : clears ovf/udf (a same-cycle error wins)
//   rd_data, rd_valid  : head word and its valid flag
//   full, empty        : occupancy flags (registered)
//   almost_full        : count >= AFULL_TH (registered)
//   count              : words held, 0..DEPTH
//   ovf, udf           : sticky overflow / underflow
// ---------------------------------------------------------------------------
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 48,
  parameter int DEPTH    = 5,
  parameter int AFULL_TH = DEPTH - 1,
  parameter int RD_EDGE  = RD_LEVEL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        ovf,
  output logic                        udf
);

  localparam int CNT_W     = cnt_width(DEPTH);
  localparam int RAM_WORDS = DEPTH - 1;
  localparam int PTR_W     = ptr_width(RAM_WORDS);

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AFULL = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] P_LAST  = PTR_W'(RAM_WORDS - 1);
  localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);

  // Registered state
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_ovf;
  logic             r_udf;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_rd_en_q;

  // Combinational control
  logic             w_rd_req;
  logic             w_pop;
  logic             w_push;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic             w_ram_empty;
  logic             w_ram_we;
  logic             w_ram_adv;
  logic [WIDTH-1:0] w_ram_rdata;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_out_data_nxt;
  logic [PTR_W-1:0] w_wr_ptr_inc;
  logic [PTR_W-1:0] w_rd_ptr_inc;

  // Read request: level, or rising edge of rd_en in legacy mode.
  assign w_rd_req  = (RD_EDGE == RD_RISE) ? (rd_en & ~r_rd_en_q) : rd_en;
  assign w_pop     = w_rd_req & r_out_valid;
  assign w_push    = wr_en & (~r_full | w_pop);
  assign w_ovf_evt = wr_en & r_full & ~w_pop;
  assign w_udf_evt = w_rd_req & ~r_out_valid;

  // The output register holds one word whenever count > 0, so the array
  // holds count-1 words; it is empty while count <= 1.
  assign w_ram_empty = (r_count <= C_ONE);

  // Words go to the array only when they cannot go straight to the output
  // register: the head is occupied and either stays, or is replaced by an
  // older word already waiting in the array.
  assign w_ram_we  = w_push & r_out_valid & ~(w_pop & w_ram_empty);
  assign w_ram_adv = w_pop & ~w_ram_empty;

  // Pointers wrap at the last array index, whatever DEPTH is.
  assign w_wr_ptr_inc = (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + P_ONE;
  assign w_rd_ptr_inc = (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + P_ONE;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Next head word: a push bypasses the array when the FIFO is empty, or
  // when the only stored word is being popped; otherwise a pop pulls the
  // oldest array word (read asynchronously before any same-edge write).
  always_comb begin
    w_out_data_nxt = r_out_data;
    if (w_push && (!r_out_valid || (w_pop && w_ram_empty))) begin
      w_out_data_nxt = wr_data;
    end else if (w_ram_adv) begin
      w_out_data_nxt = w_ram_rdata;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .WORDS (RAM_WORDS),
    .AW    (PTR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_en_q   <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == C_DEPTH);
      r_empty     <= (w_count_nxt == '0);
      r_afull     <= (w_count_nxt >= C_AFULL);
      r_out_valid <= (w_count_nxt != '0);
      // An error in the same cycle as clr_err keeps the flag set.
      r_ovf       <= w_ovf_evt | (r_ovf & ~clr_err);
      r_udf       <= w_udf_evt | (r_udf & ~clr_err);
      r_rd_en_q   <= rd_en;
      if (w_ram_we) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_ram_adv) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
    end
  end

  // Head word carries no reset; it is meaningless while rd_valid is low.
  always_ff @(posedge clk) begin
    r_out_data <= w_out_data_nxt;
  end

  assign rd_data     = r_out_data;
  assign rd_valid    = r_out_valid;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_afull;
  assign count       = r_count;
  assign ovf         = r_ovf;
  assign udf         = r_udf;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft
// Two FIFOs (level read and rising-edge read, DEPTH=5) share one stimulus
// stream. A queue-based model per FIFO predicts every output each cycle;
// directed sequences add explicit checks with fixed values.
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft;
  import fifo_pkg::*;

  localparam int W  = 16;
  localparam int D  = 5;
  localparam int AF = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         rd_en;
  logic         clr_err;

  logic [W-1:0] rdata_l, rdata_e;
  logic         rvalid_l, rvalid_e;
  logic         full_l, full_e, empty_l, empty_e, af_l, af_e;
  logic [2:0]   cnt_l, cnt_e;
  logic         ovf_l, ovf_e, udf_l, udf_e;

  sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .RD_EDGE(RD_LEVEL)) dut_l (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rdata_l), .rd_valid(rvalid_l), .full(full_l),
    .empty(empty_l), .almost_full(af_l), .count(cnt_l), .ovf(ovf_l), .udf(udf_l)
  );

  sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .RD_EDGE(RD_RISE)) dut_e (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rdata_e), .rd_valid(rvalid_e), .full(full_e),
    .empty(empty_e), .almost_full(af_e), .count(cnt_e), .ovf(ovf_e), .udf(udf_e)
  );

  // Scoreboard / reference model
  logic [W-1:0] exp_q_l[$];
  logic [W-1:0] exp_q_e[$];
  logic m_ovf_l = 1'b0, m_udf_l = 1'b0, m_ovf_e = 1'b0, m_udf_e = 1'b0;
  logic m_prev_rd = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Applies the behavioural rules for the inputs present at the last edge.
  task automatic model_step();
    logic req, v, pop, isfull, push;
    if (!rst) begin
      exp_q_l.delete();
      exp_q_e.delete();
      m_ovf_l = 1'b0; m_udf_l = 1'b0; m_ovf_e = 1'b0; m_udf_e = 1'b0;
      m_prev_rd = 1'b0;
    end else begin
      // level-read FIFO
      req    = rd_en;
      v      = (exp_q_l.size() != 0);
      pop    = req & v;
      isfull = (exp_q_l.size() == D);
      push   = wr_en & (~isfull | pop);
      m_ovf_l = (wr_en & isfull & ~pop) | (m_ovf_l & ~clr_err);
      m_udf_l = (req & ~v) | (m_udf_l & ~clr_err);
      if (pop) void'(exp_q_l.pop_front());
      if (push) exp_q_l.push_back(wr_data);
      // edge-read FIFO
      req    = rd_en & ~m_prev_rd;
      v      = (exp_q_e.size() != 0);
      pop    = req & v;
      isfull = (exp_q_e.size() == D);
      push   = wr_en & (~isfull | pop);
      m_ovf_e = (wr_en & isfull & ~pop) | (m_ovf_e & ~clr_err);
      m_udf_e = (req & ~v) | (m_udf_e & ~clr_err);
      if (pop) void'(exp_q_e.pop_front());
      if (push) exp_q_e.push_back(wr_data);
      m_prev_rd = rd_en;
    end
  endtask

  task automatic check_all();
    chk("l_count", 64'(cnt_l), 64'(exp_q_l.size()));
    chk("l_empty", 64'(empty_l), 64'(exp_q_l.size() == 0));
    chk("l_full", 64'(full_l), 64'(exp_q_l.size() == D));
    chk("l_afull", 64'(af_l), 64'(exp_q_l.size() >= AF));
    chk("l_valid", 64'(rvalid_l), 64'(exp_q_l.size() != 0));
    if (exp_q_l.size() != 0) chk("l_data", 64'(rdata_l), 64'(exp_q_l[0]));
    chk("l_ovf", 64'(ovf_l), 64'(m_ovf_l));
    chk("l_udf", 64'(udf_l), 64'(m_udf_l));
    chk("e_count", 64'(cnt_e), 64'(exp_q_e.size()));
    chk("e_empty", 64'(empty_e), 64'(exp_q_e.size() == 0));
    chk("e_full", 64'(full_e), 64'(exp_q_e.size() == D));
    chk("e_afull", 64'(af_e), 64'(exp_q_e.size() >= AF));
    chk("e_valid", 64'(rvalid_e), 64'(exp_q_e.size() != 0));
    if (exp_q_e.size() != 0) chk("e_data", 64'(rdata_e), 64'(exp_q_e[0]));
    chk("e_ovf", 64'(ovf_e), 64'(m_ovf_e));
    chk("e_udf", 64'(udf_e), 64'(m_udf_e));
  endtask

  // Driver: hold inputs across one rising edge, then model and compare.
  task automatic cycle(input logic r, input logic wr, input logic [W-1:0] d,
                       input logic rd, input logic clr);
    rst = r; wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [W-1:0] d);
    cycle(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Pop pulse followed by an idle cycle, so the edge-read FIFO sees a new edge.
  task automatic pop_pulse();
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    idle();
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
    do_reset();
    do_reset();
    chk("rst_count", 64'(cnt_l), 64'd0);
    chk("rst_empty", 64'(empty_l), 64'd1);
    chk("rst_valid", 64'(rvalid_l), 64'd0);
    chk("rst_full", 64'(full_l), 64'd0);

    // Fill to capacity, overflow once, then read back in order.
    for (int i = 0; i < 5; i++) begin
      push(W'(16'hA1 + i));
      if (i == 2) chk("fill_af_at3", 64'(af_l), 64'd0);
      if (i == 3) chk("fill_af_at4", 64'(af_l), 64'd1);
    end
    chk("fill_full", 64'(full_l), 64'd1);
    chk("fill_count", 64'(cnt_l), 64'd5);
    push(W'(16'hA6));
    chk("ovf_set", 64'(ovf_l), 64'd1);
    chk("ovf_count", 64'(cnt_l), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("fill_order", 64'(rdata_l), 64'(16'hA1 + i));
      pop_pulse();
    end
    chk("drained_empty", 64'(empty_l), 64'd1);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 64'(ovf_l), 64'd0);

    // Fall-through latency from empty, then pop back to empty.
    push(W'(16'h11));
    chk("fwft_valid", 64'(rvalid_l), 64'd1);
    chk("fwft_data", 64'(rdata_l), 64'h11);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("fwft_empty", 64'(empty_l), 64'd1);
    chk("fwft_novalid", 64'(rvalid_l), 64'd0);
    idle();

    // Simultaneous push and pop while full.
    for (int i = 0; i < 5; i++) push(W'(16'hC1 + i));
    cycle(1'b1, 1'b1, W'(16'hB0), 1'b1, 1'b0);
    chk("full_pp_count", 64'(cnt_l), 64'd5);
    chk("full_pp_ovf", 64'(ovf_l), 64'd0);
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("full_pp_order", 64'(rdata_l), 64'(16'hC2 + i));
      pop_pulse();
    end
    chk("full_pp_b0", 64'(rdata_l), 64'hB0);
    pop_pulse();

    // Streaming through the array with several pointer wraps.
    for (int i = 0; i < 3; i++) push(W'(i));
    for (int i = 3; i < 20; i++) begin
      cycle(1'b1, 1'b1, W'(i), 1'b1, 1'b0);
      chk("stream_count", 64'(cnt_l), 64'd3);
      chk("stream_data", 64'(rdata_l), 64'(i - 2));
    end
    for (int i = 17; i < 20; i++) begin
      chk("stream_tail", 64'(rdata_l), 64'(i));
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    end
    do_reset();

    // Edge-read: held rd_en pops once; rd_en on empty sets udf.
    for (int i = 0; i < 3; i++) push(W'(16'h31 + i));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("edge_one_pop", 64'(cnt_e), 64'd2);
    chk("edge_head", 64'(rdata_e), 64'h32);
    idle();
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("edge_udf", 64'(udf_e), 64'd1);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("edge_udf_clr", 64'(udf_e), 64'd0);

    // Reset mid-operation discards contents.
    for (int i = 0; i < 3; i++) push(W'(16'h41 + i));
    cycle(1'b0, 1'b1, W'(16'h99), 1'b1, 1'b1);
    chk("mid_rst_count", 64'(cnt_l), 64'd0);
    chk("mid_rst_empty", 64'(empty_l), 64'd1);
    chk("mid_rst_valid", 64'(rvalid_l), 64'd0);
    chk("mid_rst_err", 64'({ovf_l, udf_l}), 64'd0);
    push(W'(16'h77));
    chk("mid_rst_new", 64'(rdata_l), 64'h77);
    chk("mid_rst_cnt1", 64'(cnt_l), 64'd1);
    pop_pulse();

    // Randomized traffic with shifting write/read bias and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        cycle(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 99) < wp),
              W'($urandom),
              ($urandom_range(0, 99) < rp),
              ($urandom_range(0, 9) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
